// File: rtl/data_fifo_sync_mc.sv
// data_fifo_sync_mc: multi-channel gray-pointer CDC FIFO, wrclk_jit -> rdclk_jit; DATA_FIFO_SYNC_MC_LEVEL_EN adds rd_level and surplus drain.
// Latency: first word ~PRELOAD+SYNC_STAGES+2 rdclk cycles after the first write, then one word per rdclk cycle.
// Backpressure: none upstream; writes into a full FIFO are dropped (sticky ovf_err), an empty reader re-primes via FILL (sticky unf_err).
module data_fifo_sync_mc #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int DEPTH_LOG2  = 3,
    parameter int PRELOAD     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         wrclk_jit,
    input  logic                         resetn,
    input  logic                         rdclk_jit,
    input  logic                         wr_en,
    input  logic [CHANNELS*WIDTH-1:0]    async,
    output logic [CHANNELS*WIDTH-1:0]    sync,
    output logic                         sync_valid,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         error,
    output logic [DEPTH_LOG2:0]          rd_level
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int DW    = CHANNELS * WIDTH;

    typedef logic [AW:0] ptr_t;
    typedef enum logic {FILL, RUN} rd_state_t;

    localparam ptr_t PRELOAD_P = ptr_t'(PRELOAD);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // Reset synchronisers: assert asynchronously, release after two local edges
    logic [1:0] wr_rst_q;
    logic [1:0] rd_rst_q;
    logic       wr_rst_n;
    logic       rd_rst_n;

    always_ff @(posedge wrclk_jit or negedge resetn) begin
        if (!resetn) begin
            wr_rst_q <= 2'b00;
        end else begin
            wr_rst_q <= {wr_rst_q[0], 1'b1};
        end
    end

    always_ff @(posedge rdclk_jit or negedge resetn) begin
        if (!resetn) begin
            rd_rst_q <= 2'b00;
        end else begin
            rd_rst_q <= {rd_rst_q[0], 1'b1};
        end
    end

    assign wr_rst_n = wr_rst_q[1];
    assign rd_rst_n = rd_rst_q[1];

    logic [DW-1:0] mem [DEPTH];

    // Write domain
    ptr_t wptr_bin;
    ptr_t wptr_gray;
    ptr_t wptr_nxt;
    ptr_t rgray_sync [SYNC_STAGES];
    ptr_t rptr_bin_s;
    logic full;
    logic wr_accept;

    assign wptr_nxt   = wptr_bin + ptr_t'(1);
    assign rptr_bin_s = gray2bin(rgray_sync[SYNC_STAGES-1]);
    assign full       = (wptr_bin == {~rptr_bin_s[AW], rptr_bin_s[AW-1:0]});
    assign wr_accept  = wr_en && !full;

    always_ff @(posedge wrclk_jit or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
            ovf_err   <= 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ovf_err <= 1'b1;
            end else begin
                wptr_bin  <= wptr_nxt;
                wptr_gray <= bin2gray(wptr_nxt);
            end
        end
    end

    always_ff @(posedge wrclk_jit) begin
        if (wr_accept) begin
            mem[wptr_bin[AW-1:0]] <= async;
        end
    end

    ptr_t rptr_gray;

    always_ff @(posedge wrclk_jit or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= '0;
            end
        end else begin
            rgray_sync[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= rgray_sync[i-1];
            end
        end
    end

    // Read domain
    ptr_t      wgray_sync [SYNC_STAGES];
    ptr_t      wptr_bin_s;
    ptr_t      rptr_bin;
    ptr_t      rptr_nxt;
    ptr_t      rd_addr;
    ptr_t      level;
    rd_state_t state;
    logic      drain;
    logic [1:0] ovf_sync;

    always_ff @(posedge rdclk_jit or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wgray_sync[i] <= '0;
            end
        end else begin
            wgray_sync[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wgray_sync[i] <= wgray_sync[i-1];
            end
        end
    end

    assign wptr_bin_s = gray2bin(wgray_sync[SYNC_STAGES-1]);
    assign level      = wptr_bin_s - rptr_bin;

`ifdef DATA_FIFO_SYNC_MC_LEVEL_EN
    // A sustained surplus skips one entry so the level settles back near PRELOAD
    localparam ptr_t SURPLUS_P = PRELOAD_P + ptr_t'(1);
    logic [3:0] surplus_cnt;
    logic       surplus;

    assign surplus = (state == RUN) && (level > SURPLUS_P);
    assign drain   = surplus && (surplus_cnt == 4'd15);

    always_ff @(posedge rdclk_jit or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            surplus_cnt <= 4'd0;
            rd_level    <= '0;
        end else begin
            rd_level <= level;
            if (!surplus || drain) begin
                surplus_cnt <= 4'd0;
            end else begin
                surplus_cnt <= surplus_cnt + 4'd1;
            end
        end
    end
`else
    assign drain    = 1'b0;
    assign rd_level = '0;
`endif

    assign rptr_nxt = rptr_bin + (drain ? ptr_t'(2) : ptr_t'(1));
    assign rd_addr  = drain ? (rptr_bin + ptr_t'(1)) : rptr_bin;

    always_ff @(posedge rdclk_jit or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state      <= FILL;
            rptr_bin   <= '0;
            rptr_gray  <= '0;
            sync       <= '0;
            sync_valid <= 1'b0;
            unf_err    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    sync_valid <= 1'b0;
                    if (level >= PRELOAD_P) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (level != '0) begin
                        sync       <= mem[rd_addr[AW-1:0]];
                        rptr_bin   <= rptr_nxt;
                        rptr_gray  <= bin2gray(rptr_nxt);
                        sync_valid <= 1'b1;
                    end else begin
                        sync_valid <= 1'b0;
                        unf_err    <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: begin
                    state      <= FILL;
                    sync_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rdclk_jit or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            ovf_sync <= 2'b00;
        end else begin
            ovf_sync <= {ovf_sync[0], ovf_err};
        end
    end

    assign error = unf_err | ovf_sync[1];

endmodule

// File: tb/tb_data_fifo_sync_mc.sv
// Bench for data_fifo_sync_mc: jittered equal-frequency clocks, directed ramp, preload, overflow, underflow and reset scenarios.
`timescale 1ns/1ps
module tb_data_fifo_sync_mc;

    localparam int WIDTH       = 16;
    localparam int CHANNELS    = 4;
    localparam int DEPTH_LOG2  = 4;
    localparam int PRELOAD     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DW          = WIDTH * CHANNELS;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic              wrclk_jit = 1'b0;
    logic              rdclk_jit = 1'b0;
    logic              resetn    = 1'b0;
    logic              wr_en     = 1'b0;
    logic [DW-1:0]     async_d   = '0;
    logic [DW-1:0]     sync;
    logic              sync_valid;
    logic              ovf_err;
    logic              unf_err;
    logic              error;
    logic [DEPTH_LOG2:0] rd_level;

    bit  rd_run = 1'b1;
    int  chk_total = 0;
    int  chk_pass  = 0;
    int  rd_cyc    = 0;
    logic [DW-1:0] rx_q [$];
    int            rx_cyc [$];

    data_fifo_sync_mc #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH_LOG2(DEPTH_LOG2),
        .PRELOAD(PRELOAD), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .wrclk_jit (wrclk_jit),
        .resetn    (resetn),
        .rdclk_jit (rdclk_jit),
        .wr_en     (wr_en),
        .async     (async_d),
        .sync      (sync),
        .sync_valid(sync_valid),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .error     (error),
        .rd_level  (rd_level)
    );

    function automatic real jit();
        return real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
    endfunction

    // Edges sit on an ideal 5 ns grid plus bounded, non-accumulating jitter
    realtime wr_ideal = 0.0;
    realtime rd_ideal = 0.0;

    initial begin
        forever begin
            wr_ideal = wr_ideal + 5.0;
            #(wr_ideal + jit() - $realtime);
            wrclk_jit = ~wrclk_jit;
        end
    end

    initial begin
        forever begin
            rd_ideal = rd_ideal + 5.0;
            #(rd_ideal + jit() - $realtime);
            if (rd_run || rdclk_jit) rdclk_jit = ~rdclk_jit;
        end
    end

    always @(posedge rdclk_jit) begin
        #1;
        if (sync_valid === 1'b1) begin
            rx_q.push_back(sync);
            rx_cyc.push_back(rd_cyc);
        end
        rd_cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $realtime);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] pat(input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < CHANNELS; k++) begin
            w[k*WIDTH +: WIDTH] = 16'(16'h1000 * k + n);
        end
        return w;
    endfunction

    task automatic write_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wrclk_jit);
            wr_en   = 1'b1;
            async_d = pat(first + i);
        end
        @(negedge wrclk_jit);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en  = 1'b0;
        rd_run = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge wrclk_jit);
        resetn = 1'b1;
        repeat (6) @(negedge wrclk_jit);
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge rdclk_jit);
        chk_total++; if (sync !== '0) $display("FAIL reset_sync: got %0h expected 0", sync); else chk_pass++;
        chk_total++; if (sync_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sync_valid); else chk_pass++;
        chk_total++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf_err); else chk_pass++;
        chk_total++; if (unf_err !== 1'b0) $display("FAIL reset_unf: got %b expected 0", unf_err); else chk_pass++;
        chk_total++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else chk_pass++;
        chk_total++; if (rd_level !== '0) $display("FAIL reset_level: got %0d expected 0", rd_level); else chk_pass++;
    endtask

    task automatic test_preload_boundary();
        int bad;
        do_reset();
        write_words(0, PRELOAD - 1);
        repeat (20) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== 0) $display("FAIL preload_below: got %0d words expected 0", rx_q.size());
        else chk_pass++;
        write_words(PRELOAD - 1, 1);
        repeat (20) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== PRELOAD) $display("FAIL preload_count: got %0d words expected %0d", rx_q.size(), PRELOAD);
        else chk_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < PRELOAD; i++) if (rx_q[i] !== pat(i)) bad++;
        chk_total++;
        if (bad !== 0) $display("FAIL preload_data: got %0d bad words expected 0", bad); else chk_pass++;
        chk_total++;
        if (unf_err !== 1'b1) $display("FAIL preload_drain_unf: got %b expected 1", unf_err); else chk_pass++;
    endtask

    task automatic test_ramp();
        int bad;
        int gaps;
        do_reset();
        write_words(0, 1000);
        chk_total++; if (error !== 1'b0) $display("FAIL ramp_error: got %b expected 0", error); else chk_pass++;
        chk_total++; if (ovf_err !== 1'b0) $display("FAIL ramp_ovf: got %b expected 0", ovf_err); else chk_pass++;
        repeat (40) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== 1000) $display("FAIL ramp_count: got %0d expected 1000", rx_q.size()); else chk_pass++;
        bad = 0;
        gaps = 0;
        for (int i = 0; i < rx_q.size() && i < 1000; i++) begin
            if (rx_q[i] !== pat(i)) bad++;
            if (i > 0 && rx_cyc[i] != rx_cyc[i-1] + 1) gaps++;
        end
        chk_total++; if (bad !== 0) $display("FAIL ramp_data: got %0d bad words expected 0", bad); else chk_pass++;
        chk_total++; if (gaps !== 0) $display("FAIL ramp_gaps: got %0d gaps expected 0", gaps); else chk_pass++;
    endtask

    task automatic test_overflow();
        int bad;
        int waited;
        do_reset();
        @(negedge rdclk_jit);
        rd_run = 1'b0;
        repeat (4) @(negedge wrclk_jit);
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge wrclk_jit);
            if (i == DEPTH) begin
                chk_total++;
                if (ovf_err !== 1'b0) $display("FAIL ovf_at_full: got %b expected 0", ovf_err); else chk_pass++;
            end
            if (i == DEPTH + 1) begin
                chk_total++;
                if (ovf_err !== 1'b1) $display("FAIL ovf_after_drop: got %b expected 1", ovf_err); else chk_pass++;
            end
            wr_en   = 1'b1;
            async_d = pat(i);
        end
        @(negedge wrclk_jit);
        wr_en = 1'b0;
        chk_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf_err); else chk_pass++;
        chk_total++; if (error !== 1'b0) $display("FAIL ovf_error_stopped: got %b expected 0", error); else chk_pass++;
        rd_run = 1'b1;
        waited = 0;
        while (error !== 1'b1 && waited < 3) begin
            @(posedge rdclk_jit);
            #1;
            waited++;
        end
        chk_total++;
        if (error !== 1'b1) $display("FAIL ovf_error_sync: got %b after %0d rd cycles expected 1", error, waited);
        else chk_pass++;
        repeat (40) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== DEPTH) $display("FAIL ovf_count: got %0d expected %0d", rx_q.size(), DEPTH); else chk_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < DEPTH; i++) if (rx_q[i] !== pat(i)) bad++;
        chk_total++; if (bad !== 0) $display("FAIL ovf_data: got %0d bad words expected 0", bad); else chk_pass++;
    endtask

    task automatic test_underflow();
        int bad;
        do_reset();
        write_words(0, 20);
        repeat (40) @(negedge rdclk_jit);
        chk_total++; if (rx_q.size() !== 20) $display("FAIL unf_count: got %0d expected 20", rx_q.size()); else chk_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 20; i++) if (rx_q[i] !== pat(i)) bad++;
        chk_total++; if (bad !== 0) $display("FAIL unf_data: got %0d bad words expected 0", bad); else chk_pass++;
        chk_total++; if (unf_err !== 1'b1) $display("FAIL unf_flag: got %b expected 1", unf_err); else chk_pass++;
        chk_total++; if (error !== 1'b1) $display("FAIL unf_error: got %b expected 1", error); else chk_pass++;
        chk_total++; if (ovf_err !== 1'b0) $display("FAIL unf_no_ovf: got %b expected 0", ovf_err); else chk_pass++;
        write_words(20, PRELOAD - 1);
        repeat (20) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== 20) $display("FAIL unf_refill_hold: got %0d expected 20", rx_q.size()); else chk_pass++;
        write_words(20 + PRELOAD - 1, 1);
        repeat (20) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== 20 + PRELOAD) $display("FAIL unf_refill_count: got %0d expected %0d", rx_q.size(), 20 + PRELOAD);
        else chk_pass++;
        bad = 0;
        for (int i = 20; i < rx_q.size() && i < 20 + PRELOAD; i++) if (rx_q[i] !== pat(i)) bad++;
        chk_total++; if (bad !== 0) $display("FAIL unf_refill_data: got %0d bad words expected 0", bad); else chk_pass++;
    endtask

    task automatic test_reset_midstream();
        int bad;
        do_reset();
        write_words(0, 30);
        chk_total++;
        if (sync_valid !== 1'b1) $display("FAIL mid_streaming: got %b expected 1", sync_valid); else chk_pass++;
        resetn = 1'b0;
        #1;
        chk_total++; if (sync !== '0) $display("FAIL mid_sync: got %0h expected 0", sync); else chk_pass++;
        chk_total++; if (sync_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", sync_valid); else chk_pass++;
        chk_total++; if ((ovf_err | unf_err | error) !== 1'b0) $display("FAIL mid_flags: got %b expected 0", ovf_err | unf_err | error); else chk_pass++;
        chk_total++; if (rd_level !== '0) $display("FAIL mid_level: got %0d expected 0", rd_level); else chk_pass++;
        repeat (2) @(negedge wrclk_jit);
        resetn = 1'b1;
        repeat (6) @(negedge wrclk_jit);
        rx_q.delete();
        rx_cyc.delete();
        write_words(0, 1000);
        chk_total++; if (error !== 1'b0) $display("FAIL mid_post_error: got %b expected 0", error); else chk_pass++;
        repeat (40) @(negedge rdclk_jit);
        chk_total++;
        if (rx_q.size() !== 1000) $display("FAIL mid_post_count: got %0d expected 1000", rx_q.size()); else chk_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 1000; i++) if (rx_q[i] !== pat(i)) bad++;
        chk_total++; if (bad !== 0) $display("FAIL mid_post_data: got %0d bad words expected 0", bad); else chk_pass++;
    endtask

    initial begin
        test_reset();
        test_preload_boundary();
        test_ramp();
        test_overflow();
        test_underflow();
        test_reset_midstream();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
